pwm_bridge_drive: RTL and testbench
===================================

// Module: pwm_bridge_drive
// PURPOSE
//  Consumer end of the motor control block. Takes the PWM count enable, enable and
//  polarity outputs and drives the H-bridge: an 8-bit PWM generator and a direction
//  (phase) output.
//  Duty updates are double-buffered. Dead time is inserted on every direction reversal.
//  Sits between the control block and the bridge gate pins.
// PARAMETERS
//  CNT_WIDTH   8  PWM counter / duty width; period = 2**CNT_WIDTH pwmcntce ticks
//  DEAD_TICKS  16 clk cycles of forced-off PWM on a direction reversal (>=1)
//  DEAD_WIDTH  5  width of dead-time down-counter; must hold DEAD_TICKS-1
// PORTS
//  clk          in   1  system clock (sole clock)
//  reset        in   1  synchronous, active-high reset
//  pwmcntce     in   1  PWM counter advance enable (clk-wide pulse)
//  motorenaint  in   1  motor enable; low forces bridge inactive
//  invertpwm    in   1  1 = active-low PWM output
//  invphase     in   1  1 = invert phase output sense
//  dutyld       in   1  load strobe: wrtdata -> pending duty
//  dirld        in   1  load strobe: wrtdata[0] -> pending direction
//  wrtdata      in   8  host write data
//  pwm          out  1  bridge PWM drive, registered
//  phase        out  1  bridge direction drive, registered
//  pwmwrapce    out  1  one-clk pulse per PWM period, registered
//  dutyrddata   out  8  readback {pending duty}
// BEHAVIOUR
//  Reset: counter=0, dutypend=dutyact=0, dirpend=dircur=0, state=IDLE, pwm=0,
//   phase=0, pwmwrapce=0. Reset mid-period aborts the period and any dead time.
//  Counter: +1 on pwmcntce while state!=IDLE, 255->0 wrap. Held at 0 in IDLE.
//  pwmwrapce: 1 the clk after a pwmcntce that takes counter 255->0.
//  Duty: dutyact <= dutypend on the wrapping pwmcntce, or every clk while in IDLE.
//   dutyld coinciding with the wrap: wrtdata goes straight to dutyact; new value wins.
//  raw = (state==RUN) && (counter < dutyact). Duty 0 gives never active.
//   Duty 255 gives 255/256 active. No 100% mode.
//  pwm <= raw ^ invertpwm (1 clk latency). Inactive level is therefore invertpwm.
//  phase <= dircur ^ invphase (1 clk latency).
//  FSM:
//   IDLE: motorenaint=1 -> RUN, with dircur<=dirpend.
//   RUN:  dirpend!=dircur -> DEAD, with deadcnt<=DEAD_TICKS-1.
//   DEAD: raw=0 and deadcnt-- each clk. deadcnt==0 -> RUN, with dircur<=dirpend.
//   A reversal-back during DEAD does not extend the dead time. The exit latches
//    the final dirpend; if dirpend==dircur, RUN is re-entered unchanged.
//  motorenaint=0 in any state -> IDLE next clk. This takes priority over all
//   other transitions, including a simultaneous dirld.
//  phase only changes while raw is forced 0: it changes at DEAD exit or IDLE exit.
//  dutyrddata = dutypend, combinational.
// STRUCTURE
//  Shared package bdc_pkg:
//   - drive_state_t enum {IDLE, RUN, DEAD}
//   - PWM_CNT_WIDTH, DEFAULT_DEAD_TICKS constants
//  One sub-module, deadband_timer:
//   - loadable down-counter with start / done
//   - DEAD_WIDTH parameter
//  FSM, counter, duty buffer and output registers live in the top module.
// TESTING
//  1. Reset, enable=1, duty=64, pwmcntce every clk.
//     -> pwm high for 64 of each 256 clks; pwmwrapce every 256 clks.
//  2. Duty=0 then duty=255, invertpwm=0.
//     -> pwm never high; then low for exactly 1 tick/period.
//     Repeat with invertpwm=1 and check the inverted levels.
//  3. Write duty=200 at counter=10.
//     -> old duty holds to wrap; 200 takes effect from counter=0.
//     dutyld on the wrapping cycle -> new value used that period.
//  4. dirld 0->1 mid-pulse, DEAD_TICKS=16.
//     -> pwm inactive within 1 clk; held 16 clks; phase toggles at DEAD exit.
//     Toggle dir twice in DEAD -> phase unchanged at exit.
//  5. motorenaint falls mid-DEAD with a simultaneous dirld.
//     -> IDLE; pwm=invertpwm; counter=0; re-enable resumes with the new dirpend.
//  6. Reset asserted mid-period with duty=128.
//     -> pwm=0, phase=0, dutyrddata=0 the next clk.

Source files
------------

// File: rtl/bdc_pkg.sv
// Shared types and constants for the brushed-DC motor bridge drive.
package bdc_pkg;

  // Bridge drive states: parked, driving, or forced-off while reversing.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } drive_state_t;

  // PWM counter and duty register width; one period is 2**PWM_CNT_WIDTH ticks.
  localparam int PWM_CNT_WIDTH = 8;

  // Default forced-off interval, in clk cycles, on every direction reversal.
  localparam int DEFAULT_DEAD_TICKS = 16;

endpackage

// File: rtl/deadband_timer.sv
// Loadable down-counter that times the forced-off window on a direction reversal.
// 'start' loads DEAD_TICKS-1, the count falls by one per clk while 'run' is high,
// and 'done' is raised once it reaches zero.
module deadband_timer #(
  parameter int DEAD_TICKS = 16,
  parameter int DEAD_WIDTH = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  input  logic clear,
  output logic done
);

  localparam logic [DEAD_WIDTH-1:0] LOAD_VALUE = DEAD_WIDTH'(DEAD_TICKS - 1);

  logic [DEAD_WIDTH-1:0] count;

  // Load on start, drop back to zero when the bridge is parked, else count down.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= LOAD_VALUE;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != '0)) begin
      count <= count - DEAD_WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pwm_bridge_drive.sv
// H-bridge drive: double-buffered PWM generator plus direction output, with a
// dead-time window forced on every direction reversal.
module pwm_bridge_drive
  import bdc_pkg::*;
#(
  parameter int CNT_WIDTH  = PWM_CNT_WIDTH,
  parameter int DEAD_TICKS = DEFAULT_DEAD_TICKS,
  parameter int DEAD_WIDTH = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwmcntce,
  input  logic       motorenaint,
  input  logic       invertpwm,
  input  logic       invphase,
  input  logic       dutyld,
  input  logic       dirld,
  input  logic [7:0] wrtdata,
  output logic       pwm,
  output logic       phase,
  output logic       pwmwrapce,
  output logic [7:0] dutyrddata
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  drive_state_t state;
  drive_state_t state_next;

  logic [CNT_WIDTH-1:0] counter;
  logic [CNT_WIDTH-1:0] duty_pend;
  logic [CNT_WIDTH-1:0] duty_act;
  logic                 dir_pend;
  logic                 dir_cur;

  logic wrap_tick;
  logic raw;
  logic dir_load;
  logic dead_start;
  logic dead_done;

  assign wrap_tick = pwmcntce && (state != IDLE) && (counter == CNT_MAX);
  assign raw       = (state == RUN) && (counter < duty_act);

  deadband_timer #(
    .DEAD_TICKS (DEAD_TICKS),
    .DEAD_WIDTH (DEAD_WIDTH)
  ) u_deadband (
    .clk   (clk),
    .reset (reset),
    .start (dead_start),
    .run   (state == DEAD),
    .clear (state == IDLE),
    .done  (dead_done)
  );

  // Drive state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; losing the enable parks the bridge ahead of anything else.
  always_comb begin
    state_next = state;
    dir_load   = 1'b0;
    dead_start = 1'b0;
    if (!motorenaint) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_next = RUN;
          dir_load   = 1'b1;
        end
        RUN: begin
          if (dir_pend != dir_cur) begin
            state_next = DEAD;
            dead_start = 1'b1;
          end
        end
        DEAD: begin
          if (dead_done) begin
            state_next = RUN;
            dir_load   = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // PWM period counter, parked at zero while the bridge is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
    end else if (state == IDLE) begin
      counter <= '0;
    end else if (pwmcntce) begin
      counter <= counter + CNT_WIDTH'(1);
    end
  end

  // Duty double buffer: a write landing on the wrap goes straight to the active copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_pend <= '0;
      duty_act  <= '0;
    end else begin
      if (dutyld) begin
        duty_pend <= CNT_WIDTH'(wrtdata);
      end
      if (state == IDLE) begin
        duty_act <= duty_pend;
      end else if (wrap_tick) begin
        duty_act <= dutyld ? CNT_WIDTH'(wrtdata) : duty_pend;
      end
    end
  end

  // Requested and applied direction; the applied one only moves while PWM is forced off.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_pend <= 1'b0;
      dir_cur  <= 1'b0;
    end else begin
      if (dirld) begin
        dir_pend <= wrtdata[0];
      end
      if (dir_load) begin
        dir_cur <= dir_pend;
      end
    end
  end

  // Registered bridge pins and period marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm       <= 1'b0;
      phase     <= 1'b0;
      pwmwrapce <= 1'b0;
    end else begin
      pwm       <= raw ^ invertpwm;
      phase     <= dir_cur ^ invphase;
      pwmwrapce <= wrap_tick;
    end
  end

  assign dutyrddata = 8'(duty_pend);

endmodule

// File: tb/tb_pwm_bridge_drive.sv
// Self-checking bench for pwm_bridge_drive: directed scenarios followed by a
// random soak, every cycle compared against a behavioural model of the bridge.
module tb_pwm_bridge_drive;

  localparam int PERIOD = 256;
  localparam int DEAD_T = 16;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DEAD = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       pwmcntce;
  logic       motorenaint;
  logic       invertpwm;
  logic       invphase;
  logic       dutyld;
  logic       dirld;
  logic [7:0] wrtdata;
  logic       pwm;
  logic       phase;
  logic       pwmwrapce;
  logic [7:0] dutyrddata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model state
  int m_mode, m_cnt, m_pend, m_act, m_dirpend, m_dircur, m_dead_left;
  int m_pwm, m_phase, m_wrap;

  pwm_bridge_drive dut (
    .clk         (clk),
    .reset       (reset),
    .pwmcntce    (pwmcntce),
    .motorenaint (motorenaint),
    .invertpwm   (invertpwm),
    .invphase    (invphase),
    .dutyld      (dutyld),
    .dirld       (dirld),
    .wrtdata     (wrtdata),
    .pwm         (pwm),
    .phase       (phase),
    .pwmwrapce   (pwmwrapce),
    .dutyrddata  (dutyrddata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clk edge of the bridge, computed from the rules of operation.
  task automatic modelEdge(input bit r, input bit ce, input bit en, input bit inv,
                           input bit iph, input bit dld, input bit rld, input int wd);
    int  n_mode, n_cnt, n_act, n_dircur, n_dead;
    bit  active, wrapping;
    if (r) begin
      m_mode = M_IDLE; m_cnt = 0; m_pend = 0; m_act = 0; m_dirpend = 0;
      m_dircur = 0; m_dead_left = 0; m_pwm = 0; m_phase = 0; m_wrap = 0;
      return;
    end
    active   = (m_mode == M_RUN) && (m_cnt < m_act);
    wrapping = (m_mode != M_IDLE) && ce && (m_cnt == PERIOD - 1);
    m_pwm    = int'(active ^ inv);
    m_phase  = m_dircur ^ int'(iph);
    m_wrap   = int'(wrapping);
    n_cnt    = (m_mode == M_IDLE) ? 0 : (ce ? (m_cnt + 1) % PERIOD : m_cnt);
    if (m_mode == M_IDLE) n_act = m_pend;
    else if (wrapping)    n_act = dld ? wd : m_pend;
    else                  n_act = m_act;
    n_mode = m_mode; n_dircur = m_dircur; n_dead = m_dead_left;
    if (!en) begin
      n_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      n_mode = M_RUN; n_dircur = m_dirpend;
    end else if (m_mode == M_RUN) begin
      if (m_dirpend != m_dircur) begin
        n_mode = M_DEAD; n_dead = DEAD_T;
      end
    end else begin
      if (m_dead_left == 1) begin
        n_mode = M_RUN; n_dircur = m_dirpend;
      end else begin
        n_dead = m_dead_left - 1;
      end
    end
    if (dld) m_pend = wd;
    if (rld) m_dirpend = wd % 2;
    m_mode = n_mode; m_cnt = n_cnt; m_act = n_act; m_dircur = n_dircur; m_dead_left = n_dead;
  endtask

  // Apply the current inputs across one clk edge and compare every output.
  task automatic applyStimulus();
    bit r, ce, en, inv, iph, dld, rld;
    int wd;
    r = reset; ce = pwmcntce; en = motorenaint; inv = invertpwm; iph = invphase;
    dld = dutyld; rld = dirld; wd = int'(wrtdata);
    @(posedge clk);
    modelEdge(r, ce, en, inv, iph, dld, rld, wd);
    #1;
    cyc++;
    checkOutput("pwm", 16'(pwm), 16'(m_pwm));
    checkOutput("phase", 16'(phase), 16'(m_phase));
    checkOutput("pwmwrapce", 16'(pwmwrapce), 16'(m_wrap));
    checkOutput("dutyrddata", 16'(dutyrddata), 16'(m_pend));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic writeDuty(input int d);
    dutyld = 1'b1; wrtdata = 8'(d);
    applyStimulus();
    dutyld = 1'b0;
  endtask

  task automatic writeDir(input bit d);
    dirld = 1'b1; wrtdata = {7'd0, d};
    applyStimulus();
    dirld = 1'b0;
  endtask

  // Advance until the model's counter reaches 'target'; a miss counts as a failure.
  task automatic waitCount(input int target);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * PERIOD && !hit; i++) begin
      if (m_cnt == target) hit = 1'b1;
      else applyStimulus();
    end
    checkOutput("wait_counter", 16'(hit), 16'd1);
  endtask

  // Count pwm-high cycles over one full period.
  task automatic countHigh(output int hi);
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      applyStimulus();
      hi += int'(pwm);
    end
  endtask

  initial begin
    int hi, inactive, first_wrap, second_wrap, ph_before;

    reset = 1'b1; pwmcntce = 1'b0; motorenaint = 1'b0; invertpwm = 1'b0;
    invphase = 1'b0; dutyld = 1'b0; dirld = 1'b0; wrtdata = 8'd0;
    m_mode = M_IDLE; m_cnt = 0; m_pend = 0; m_act = 0; m_dirpend = 0;
    m_dircur = 0; m_dead_left = 0; m_pwm = 0; m_phase = 0; m_wrap = 0;

    $display("[TB] reset state");
    runCycles(3);
    checkOutput("reset_pwm", 16'(pwm), 16'd0);
    checkOutput("reset_phase", 16'(phase), 16'd0);
    checkOutput("reset_rd", 16'(dutyrddata), 16'd0);
    reset = 1'b0;

    $display("[TB] duty 64, continuous advance");
    writeDuty(64);
    motorenaint = 1'b1; pwmcntce = 1'b1;
    runCycles(300);
    countHigh(hi);
    checkOutput("duty64_high", 16'(hi), 16'd64);
    first_wrap = -1; second_wrap = -1;
    for (int i = 0; i < 600 && second_wrap < 0; i++) begin
      applyStimulus();
      if (pwmwrapce) begin
        if (first_wrap < 0) first_wrap = cyc;
        else second_wrap = cyc;
      end
    end
    checkOutput("wrap_interval", 16'(second_wrap - first_wrap), 16'(PERIOD));

    $display("[TB] duty extremes");
    writeDuty(0);   runCycles(300); countHigh(hi);
    checkOutput("duty0_high", 16'(hi), 16'd0);
    writeDuty(255); runCycles(300); countHigh(hi);
    checkOutput("duty255_high", 16'(hi), 16'd255);
    invertpwm = 1'b1; runCycles(4); countHigh(hi);
    checkOutput("duty255_inv_high", 16'(hi), 16'd1);
    writeDuty(0);   runCycles(300); countHigh(hi);
    checkOutput("duty0_inv_high", 16'(hi), 16'd256);
    invertpwm = 1'b0;

    $display("[TB] double-buffered duty");
    writeDuty(50); runCycles(300);
    waitCount(10);
    writeDuty(200);
    runCycles(300);
    waitCount(255);
    writeDuty(30);
    countHigh(hi);
    checkOutput("wrap_write_high", 16'(hi), 16'd30);

    $display("[TB] direction reversal");
    writeDuty(200); runCycles(300);
    waitCount(20);
    ph_before = int'(phase);
    writeDir(1'b1);
    inactive = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (!pwm) inactive++;
      if (i == 16) checkOutput("phase_held_in_dead", 16'(phase), 16'(ph_before));
    end
    checkOutput("dead_inactive", 16'(inactive), 16'(DEAD_T));
    checkOutput("phase_after_dead", 16'(phase), 16'(ph_before ^ 1));
    waitCount(100);
    ph_before = int'(phase);
    writeDir(1'b0); runCycles(4);
    writeDir(1'b1); runCycles(25);
    checkOutput("double_toggle_phase", 16'(phase), 16'(ph_before));

    $display("[TB] disable during dead time");
    invertpwm = 1'b1;
    waitCount(40);
    writeDir(1'b0); runCycles(5);
    motorenaint = 1'b0; dirld = 1'b1; wrtdata = 8'd0;
    applyStimulus();
    dirld = 1'b0;
    runCycles(3);
    checkOutput("idle_pwm_inactive", 16'(pwm), 16'd1);
    motorenaint = 1'b1;
    runCycles(4);
    checkOutput("resume_phase", 16'(phase), 16'd0);

    $display("[TB] reset mid-period");
    invertpwm = 1'b0; invphase = 1'b1;
    writeDuty(128); runCycles(300);
    waitCount(60);
    reset = 1'b1;
    applyStimulus();
    checkOutput("midreset_pwm", 16'(pwm), 16'd0);
    checkOutput("midreset_phase", 16'(phase), 16'd0);
    checkOutput("midreset_rd", 16'(dutyrddata), 16'd0);
    reset = 1'b0;

    $display("[TB] random soak");
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(499) == 0);
      pwmcntce    = ($urandom_range(3) != 0);
      if ($urandom_range(199) == 0) motorenaint = ~motorenaint;
      if ($urandom_range(299) == 0) invertpwm = ~invertpwm;
      if ($urandom_range(299) == 0) invphase = ~invphase;
      dutyld      = ($urandom_range(39) == 0);
      dirld       = ($urandom_range(59) == 0);
      wrtdata     = 8'($urandom);
      applyStimulus();
    end
    reset = 1'b0; dutyld = 1'b0; dirld = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
